alu_op_sequencer: RTL



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_sync_fifo.sv | 58 +++++
 rtl/alu_op_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and opcode classification helpers for the ALU issue logic.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_SRA = 4'd3;
  localparam logic [3:0] OP_NOP = 4'hF;

  // Per-op bookkeeping that travels alongside the ALU in the shadow pipeline.
  typedef struct packed {
    logic v;
    logic carry_en;
    logic err;
  } shadow_flags_t;

  function automatic logic is_carry_op(input logic [3:0] opcode);
    return (opcode == OP_ADD) || (opcode == OP_SUB);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] opcode);
    return opcode <= OP_SRA;
  endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Single-clock FIFO with combinational head read; push while full is accepted only with a pop.
module alu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + (PW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the pipelined ALU: buffers requests, issues with result-FIFO credits,
// tracks ALU latency in a shadow pipeline and returns tagged responses in order.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int TAG_W     = 4,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int ALU_LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [4:0]       cmd_shift,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int CMD_W = 4 + 2*WIDTH + 5 + TAG_W;
  localparam int RES_W = WIDTH + 2 + TAG_W;
  localparam int CCW   = $clog2(CMD_DEPTH) + 1;
  localparam int RCW   = $clog2(RES_DEPTH) + 1;
  localparam int IFW   = $clog2(ALU_LAT) + 1;

  // Command FIFO
  logic             cmd_push, cmd_full, cmd_empty;
  logic [CCW-1:0]   cmd_count;
  logic [CMD_W-1:0] cmd_wdata, cmd_head;
  logic [3:0]       head_opcode;
  logic [WIDTH-1:0] head_a, head_b;
  logic [4:0]       head_shift;
  logic [TAG_W-1:0] head_tag;

  // Result FIFO
  logic             res_push, res_pop, res_full, res_empty;
  logic [RCW-1:0]   res_count;
  logic [RES_W-1:0] res_wdata, res_head;

  // Issue and shadow pipeline
  logic             issue;
  int               res_after_pop;
  logic [3:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [4:0]       alu_shift_q, alu_shift_d;
  logic [IFW-1:0]   inflight_q, inflight_d;
  shadow_flags_t    sh_q [ALU_LAT+1];
  shadow_flags_t    sh_d [ALU_LAT+1];
  logic [TAG_W-1:0] sh_tag_q [ALU_LAT+1];
  logic [TAG_W-1:0] sh_tag_d [ALU_LAT+1];
  logic             cap_v;
  logic             unused_sigs;

  assign cmd_ready = !cmd_full && !rst;
  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_wdata = {cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag};
  assign {head_opcode, head_a, head_b, head_shift, head_tag} = cmd_head;

  alu_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .pop   (issue),
    .wdata (cmd_wdata),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  // Stage 0 rides alongside the alu_* register; stage ALU_LAT lines up with alu_result.
  assign cap_v     = sh_q[ALU_LAT].v;
  assign res_push  = cap_v;
  assign res_wdata = {alu_result, alu_carry & sh_q[ALU_LAT].carry_en,
                      sh_q[ALU_LAT].err, sh_tag_q[ALU_LAT]};
  assign res_pop   = rsp_valid && rsp_ready;

  alu_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push),
    .pop   (res_pop),
    .wdata (res_wdata),
    .rdata (res_head),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  assign rsp_valid = !res_empty;
  assign {rsp_result, rsp_carry, rsp_err, rsp_tag} = res_head;
  assign busy = (cmd_count != '0) || (inflight_q != '0) || !res_empty;

  // The credit rule alone prevents result overflow, so full is never consulted.
  assign unused_sigs = res_full;

  assign alu_opcode     = alu_opcode_q;
  assign alu_input1     = alu_a_q;
  assign alu_input2     = alu_b_q;
  assign alu_shiftValue = alu_shift_q;

  always_comb begin
    res_after_pop = int'(res_count) - int'(res_pop);
    issue = !cmd_empty && ((int'(inflight_q) + res_after_pop) < RES_DEPTH);

    alu_opcode_d = issue ? head_opcode : OP_NOP;
    alu_a_d      = issue ? head_a      : alu_a_q;
    alu_b_d      = issue ? head_b      : alu_b_q;
    alu_shift_d  = issue ? head_shift  : alu_shift_q;

    inflight_d = inflight_q;
    if (issue && !cap_v)      inflight_d = inflight_q + IFW'(1);
    else if (!issue && cap_v) inflight_d = inflight_q - IFW'(1);

    sh_d[0].v        = issue;
    sh_d[0].carry_en = is_carry_op(head_opcode);
    sh_d[0].err      = !is_legal_op(head_opcode);
    sh_tag_d[0]      = head_tag;
    for (int i = 1; i <= ALU_LAT; i++) begin
      sh_d[i]     = sh_q[i-1];
      sh_tag_d[i] = sh_tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode_q <= OP_NOP;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_shift_q  <= '0;
      inflight_q   <= '0;
      for (int i = 0; i <= ALU_LAT; i++) begin
        sh_q[i]     <= '0;
        sh_tag_q[i] <= '0;
      end
    end else begin
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_shift_q  <= alu_shift_d;
      inflight_q   <= inflight_d;
      for (int i = 0; i <= ALU_LAT; i++) begin
        sh_q[i]     <= sh_d[i];
        sh_tag_q[i] <= sh_tag_d[i];
      end
    end
  end

endmodule
